// File: rtl/vga_tile_framebuffer_if.sv
// Writer-side bus of the tile framebuffer: single-cell writes with valid/ready,
// plus the full-screen clear request and its busy indication.
interface vga_tile_framebuffer_if;
  logic       wr_en;
  logic [6:0] wr_col;
  logic [5:0] wr_row;
  logic [2:0] wr_color;
  logic       wr_ready;
  logic       clear;
  logic [2:0] clear_color;
  logic       busy;

  modport master (
    output wr_en, wr_col, wr_row, wr_color, clear, clear_color,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_en, wr_col, wr_row, wr_color, clear, clear_color,
    output wr_ready, busy
  );
endinterface

// File: rtl/vga_tile_framebuffer.sv
// Tile framebuffer: 80x60 cells of 8x8 pixels, one 3-bit colour per cell, read by the
// VGA sync stage with a fixed 2-clock latency and written one cell at a time or by a clear sweep.
module vga_tile_framebuffer #(
  parameter int unsigned HCells       = 80,
  parameter int unsigned VCells       = 60,
  parameter int unsigned CellShift    = 3,
  parameter logic [2:0]  DefaultColor = 3'b100
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [9:0]                   col_i,
  input  logic [9:0]                   row_i,
  input  logic                         visible_i,
  output logic                         red_o,
  output logic                         green_o,
  output logic                         blue_o,
  vga_tile_framebuffer_if.slave        wr_bus
);

  localparam int unsigned Cells    = HCells * VCells;
  localparam int unsigned AddrW    = $clog2(Cells);
  localparam logic [9:0]  PixCols  = 10'(HCells << CellShift);
  localparam logic [9:0]  PixRows  = 10'(VCells << CellShift);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Cells - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic [2:0]       clr_color_q, clr_color_d;

  logic [2:0]       mem_q [Cells];

  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [2:0]       mem_wdata;
  logic             wr_ready;
  logic             busy;

  // Read-side address: row*80 built from shifts, clamped to 0 outside the active area
  logic [9:0]       rd_cell_col, rd_cell_row;
  logic [AddrW-1:0] rd_row_ext, rd_addr;
  logic             rd_in_area;

  always_comb begin
    rd_cell_col = col_i >> CellShift;
    rd_cell_row = row_i >> CellShift;
    rd_row_ext  = AddrW'(rd_cell_row);
    rd_in_area  = (col_i < PixCols) && (row_i < PixRows);
    rd_addr     = rd_in_area ? (rd_row_ext << 6) + (rd_row_ext << 4) + AddrW'(rd_cell_col)
                             : '0;
  end

  logic [AddrW-1:0] wr_row_ext, wr_addr;
  logic             wr_in_range;

  always_comb begin
    wr_row_ext  = AddrW'(wr_bus.wr_row);
    wr_addr     = (wr_row_ext << 6) + (wr_row_ext << 4) + AddrW'(wr_bus.wr_col);
    wr_in_range = (wr_bus.wr_col < 7'(HCells)) && (wr_bus.wr_row < 6'(VCells));
  end

  // Read pipeline: stage 1 registers address/visible, stage 2 registers the colour
  logic [AddrW-1:0] rd_addr_q;
  logic             rd_vis_q;
  logic [2:0]       rgb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr_q <= '0;
      rd_vis_q  <= 1'b0;
      rgb_q     <= '0;
    end else begin
      rd_addr_q <= rd_addr;
      rd_vis_q  <= visible_i && rd_in_area;
      rgb_q     <= rd_vis_q ? mem_q[rd_addr_q] : 3'b000;
    end
  end

  assign red_o   = rgb_q[2];
  assign green_o = rgb_q[1];
  assign blue_o  = rgb_q[0];

  // Contents are never reset; the post-reset sweep initialises them
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StClear;
      cnt_q       <= '0;
      clr_color_q <= DefaultColor;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_color_q <= clr_color_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_color_d = clr_color_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_ready = 1'b1;
        // Out-of-range writes still complete the handshake but touch nothing
        if (wr_bus.wr_en && wr_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_bus.wr_color;
        end
        if (wr_bus.clear) begin
          state_d     = StClear;
          clr_color_d = wr_bus.clear_color;
        end
      end
      StClear: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = clr_color_q;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign wr_bus.wr_ready = wr_ready;
  assign wr_bus.busy     = busy;

endmodule

// File: tb/tb_vga_tile_framebuffer.sv
// Directed bench for vga_tile_framebuffer: a cell-level screen model predicts every pixel and
// the busy/ready flags each cycle, plus literal probes for the key scenarios.
module tb_vga_tile_framebuffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] col, row;
  logic       vis;
  logic       red, green, blue;

  vga_tile_framebuffer_if wr_bus();

  vga_tile_framebuffer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .col_i     (col),
    .row_i     (row),
    .visible_i (vis),
    .red_o     (red),
    .green_o   (green),
    .blue_o    (blue),
    .wr_bus    (wr_bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Screen model: cell colours, cycles of clear sweep still to run, sweep colour
  logic [2:0] mmem [4800];
  int         left;
  logic [2:0] mclr;
  logic [2:0] exp_rgb;
  bit         pend_vis;
  int         pend_addr;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      left     = 4800;
      mclr     = 3'b100;
      exp_rgb  = 3'b000;
      pend_vis = 1'b0;
    end else begin
      exp_rgb = pend_vis ? mmem[pend_addr] : 3'b000;
      if (left > 0) begin
        mmem[4800 - left] = mclr;
        left--;
      end else begin
        if (wr_bus.wr_en && int'(wr_bus.wr_col) < 80 && int'(wr_bus.wr_row) < 60)
          mmem[int'(wr_bus.wr_row) * 80 + int'(wr_bus.wr_col)] = wr_bus.wr_color;
        if (wr_bus.clear) begin
          left = 4800;
          mclr = wr_bus.clear_color;
        end
      end
      pend_vis  = vis && int'(col) < 640 && int'(row) < 480;
      pend_addr = (int'(row) / 8) * 80 + int'(col) / 8;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("pixel", {red, green, blue}, exp_rgb);
      check("busy", {2'b00, wr_bus.busy}, {2'b00, left > 0});
      check("ready", {2'b00, wr_bus.wr_ready}, {2'b00, left == 0});
    end
  end

  task automatic probe(input int c, input int r, input logic v, input logic [2:0] exp,
                       input string name);
    @(negedge clk);
    col = 10'(c);
    row = 10'(r);
    vis = v;
    @(negedge clk);
    @(negedge clk);
    check(name, {red, green, blue}, exp);
    vis = 1'b0;
  endtask

  task automatic do_write(input int c, input int r, input logic [2:0] colr);
    int n = 0;
    @(negedge clk);
    wr_bus.wr_en    = 1'b1;
    wr_bus.wr_col   = 7'(c);
    wr_bus.wr_row   = 6'(r);
    wr_bus.wr_color = colr;
    while (!wr_bus.wr_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("wr_handshake", {2'b00, wr_bus.wr_ready}, 3'b001);
    @(negedge clk);
    wr_bus.wr_en = 1'b0;
  endtask

  // Counts busy cycles, scanning pixels meanwhile; optionally re-pulses clear at cycle 100
  task automatic count_busy(input bit pulse, output int n);
    n = 0;
    while (wr_bus.busy && n < 10000) begin
      wr_bus.clear       = pulse && (n == 100);
      wr_bus.clear_color = 3'b110;
      wr_bus.wr_en       = 1'b0;
      col = 10'((n % 80) * 8);
      row = 10'(((n / 80) % 60) * 8);
      vis = 1'b1;
      n++;
      @(negedge clk);
    end
    wr_bus.clear = 1'b0;
    vis          = 1'b0;
  endtask

  task automatic scan_uniform(input logic [2:0] exp, input string name);
    for (int i = 0; i < 4802; i++) begin
      @(negedge clk);
      if (i >= 2) check(name, {red, green, blue}, exp);
      if (i < 4800) begin
        col = 10'((i % 80) * 8 + (i % 8));
        row = 10'((i / 80) * 8 + ((i / 3) % 8));
        vis = 1'b1;
      end else begin
        vis = 1'b0;
      end
    end
  endtask

  int n;

  initial begin
    rst                = 1'b1;
    col                = '0;
    row                = '0;
    vis                = 1'b0;
    wr_bus.wr_en       = 1'b0;
    wr_bus.wr_col      = '0;
    wr_bus.wr_row      = '0;
    wr_bus.wr_color    = '0;
    wr_bus.clear       = 1'b0;
    wr_bus.clear_color = '0;

    // Initial sweep after a one-cycle reset
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("init_ready_low", {2'b00, wr_bus.wr_ready}, 3'b000);
    check("init_rgb_zero", {red, green, blue}, 3'b000);
    n = 0;
    while (wr_bus.busy && n < 10000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 4800) begin
      failures++;
      $display("FAIL init_busy_len: got %0d expected 4800", n);
    end
    scan_uniform(3'b100, "init_screen");

    // Single-cell write and its pixel footprint
    do_write(5, 3, 3'b010);
    probe(40, 24, 1'b1, 3'b010, "cell_5_3_tl");
    probe(47, 31, 1'b1, 3'b010, "cell_5_3_br");
    probe(39, 24, 1'b1, 3'b100, "left_neighbour");
    probe(48, 31, 1'b1, 3'b100, "right_neighbour");
    probe(44, 23, 1'b1, 3'b100, "upper_neighbour");
    for (int r = 23; r <= 32; r++) begin
      for (int c = 39; c <= 48; c++) begin
        @(negedge clk);
        col = 10'(c);
        row = 10'(r);
        vis = 1'b1;
      end
    end
    @(negedge clk);
    vis = 1'b0;

    // Read and write of the same cell at the same edge returns the old colour
    @(negedge clk);
    col = 10'd80;
    row = 10'd80;
    vis = 1'b1;
    @(negedge clk);
    wr_bus.wr_en    = 1'b1;
    wr_bus.wr_col   = 7'd10;
    wr_bus.wr_row   = 6'd10;
    wr_bus.wr_color = 3'b011;
    @(negedge clk);
    wr_bus.wr_en = 1'b0;
    check("rw_same_old", {red, green, blue}, 3'b100);
    @(negedge clk);
    check("rw_same_new", {red, green, blue}, 3'b011);
    vis = 1'b0;

    // Out-of-range writes complete but change nothing
    do_write(80, 0, 3'b111);
    do_write(0, 60, 3'b111);
    probe(0, 8, 1'b1, 3'b100, "oob_write_alias");
    probe(639, 479, 1'b1, 3'b100, "oob_write_last");

    // Invisible and off-screen pixels read black, stored colours intact
    probe(40, 24, 1'b0, 3'b000, "invisible");
    probe(40, 24, 1'b1, 3'b010, "visible_again");
    probe(640, 0, 1'b1, 3'b000, "col_640");
    probe(0, 480, 1'b1, 3'b000, "row_480");
    probe(1023, 1023, 1'b1, 3'b000, "far_offscreen");

    // Clear with a coincident write, then a second clear pulse mid-sweep that must be ignored
    @(negedge clk);
    wr_bus.clear       = 1'b1;
    wr_bus.clear_color = 3'b001;
    wr_bus.wr_en       = 1'b1;
    wr_bus.wr_col      = 7'd0;
    wr_bus.wr_row      = 6'd0;
    wr_bus.wr_color    = 3'b111;
    @(negedge clk);
    count_busy(1'b1, n);
    checks++;
    if (n != 4800) begin
      failures++;
      $display("FAIL clear_busy_len: got %0d expected 4800", n);
    end
    probe(0, 0, 1'b1, 3'b001, "clear_cell0");
    scan_uniform(3'b001, "clear_screen");

    // Reset 2000 cycles into a sweep restarts it with the default colour
    @(negedge clk);
    wr_bus.clear       = 1'b1;
    wr_bus.clear_color = 3'b011;
    @(negedge clk);
    wr_bus.clear = 1'b0;
    repeat (1999) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(1'b0, n);
    checks++;
    if (n != 4800) begin
      failures++;
      $display("FAIL reset_busy_len: got %0d expected 4800", n);
    end
    scan_uniform(3'b100, "reset_screen");

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
